// File: rtl/bfp_dot_accum.sv
// Block-floating-point dot product per beat with frame accumulation across beats.
// Pipeline: S1 lane products, S2 adder tree, S3 aligned accumulate, final stage, output register.
module bfp_dot_accum #(
  parameter int LANES = 16,
  parameter int MW    = 4,
  parameter int EW    = 8,
  parameter int BIAS  = 127,
  parameter int ACCW  = 24,
  parameter int CNTW  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_last,
  input  logic [EW-1:0]         i_Act_E,
  input  logic [LANES*MW-1:0]   i_Act_M,
  input  logic [EW-1:0]         i_Weight_E,
  input  logic [LANES*MW-1:0]   i_Weight_M,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [EW-1:0]         o_result_E,
  output logic [ACCW-1:0]       o_result_M,
  output logic                  o_ovf,
  output logic [CNTW-1:0]       o_beats
);

  localparam int PW  = 2 * (MW - 1);
  localparam int SPW = PW + 1;
  localparam logic signed [ACCW-1:0] MAXV = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {1'b1, {(ACCW-1){1'b0}}};

  logic w_en;

  logic signed [SPW-1:0] w_prod [LANES];
  logic signed [EW+1:0]  w_expRaw;
  logic [EW-1:0]         w_expClamp;

  logic                  r_s1Valid, r_s1Last;
  logic [EW-1:0]         r_s1E;
  logic signed [SPW-1:0] r_s1Prod [LANES];

  logic signed [ACCW-1:0] w_sum;
  logic                   r_s2Valid, r_s2Last;
  logic [EW-1:0]          r_s2E;
  logic signed [ACCW-1:0] r_s2Sum;

  logic                   r_accFull, r_accOvf;
  logic [EW-1:0]          r_accE;
  logic signed [ACCW-1:0] r_accM;
  logic [CNTW-1:0]        r_cnt;

  logic [EW-1:0]          w_diff;
  logic signed [ACCW-1:0] w_alA, w_alB, w_newM;
  logic signed [ACCW:0]   w_wide;
  logic [EW-1:0]          w_newE;
  logic                   w_sat;
  logic [CNTW-1:0]        w_cntNext;

  logic                   r_finValid, r_finOvf;
  logic [EW-1:0]          r_finE;
  logic [ACCW-1:0]        r_finM;
  logic [CNTW-1:0]        r_finBeats;

  logic                   r_oValid, r_oOvf;
  logic [EW-1:0]          r_oE;
  logic [ACCW-1:0]        r_oM;
  logic [CNTW-1:0]        r_oBeats;

  assign w_en    = !(r_oValid && !i_ready);
  assign o_ready = w_en;

  // Sign-magnitude lane products; a zero magnitude always yields +0.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [MW-1:0] w_a, w_b;
    logic [PW-1:0] w_mag;
    logic          w_neg;
    assign w_a   = i_Act_M[g*MW +: MW];
    assign w_b   = i_Weight_M[g*MW +: MW];
    assign w_mag = PW'(w_a[MW-2:0]) * PW'(w_b[MW-2:0]);
    assign w_neg = w_a[MW-1] ^ w_b[MW-1];
    assign w_prod[g] = w_neg ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
  end

  always_comb begin
    w_expRaw = $signed({2'b00, i_Act_E}) + $signed({2'b00, i_Weight_E})
               - $signed((EW+2)'(BIAS));
    if (w_expRaw < 0)
      w_expClamp = '0;
    else if (w_expRaw > $signed({2'b00, {EW{1'b1}}}))
      w_expClamp = '1;
    else
      w_expClamp = w_expRaw[EW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
      r_s1E     <= '0;
      for (int i = 0; i < LANES; i++) r_s1Prod[i] <= '0;
    end else if (w_en) begin
      r_s1Valid <= i_valid;
      if (i_valid) begin
        r_s1Last <= i_last;
        r_s1E    <= w_expClamp;
        for (int i = 0; i < LANES; i++) r_s1Prod[i] <= w_prod[i];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++)
      w_sum = w_sum + {{(ACCW-SPW){r_s1Prod[i][SPW-1]}}, r_s1Prod[i]};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s2Valid <= 1'b0;
      r_s2Last  <= 1'b0;
      r_s2E     <= '0;
      r_s2Sum   <= '0;
    end else if (w_en) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Last <= r_s1Last;
        r_s2E    <= r_s1E;
        r_s2Sum  <= w_sum;
      end
    end
  end

  // Arithmetic right shift; distances of ACCW or more leave only sign bits.
  function automatic logic signed [ACCW-1:0] shr(input logic signed [ACCW-1:0] x,
                                                 input logic [EW-1:0] d);
    if (int'(d) >= ACCW) return {ACCW{x[ACCW-1]}};
    return x >>> d;
  endfunction

  always_comb begin
    w_diff = '0;
    w_alA  = r_accM;
    w_alB  = r_s2Sum;
    w_newE = r_s2E;
    w_wide = '0;
    w_newM = r_s2Sum;
    w_sat  = 1'b0;
    w_cntNext = (r_cnt == {CNTW{1'b1}}) ? r_cnt : r_cnt + CNTW'(1);
    if (r_accFull) begin
      if (r_s2E > r_accE) begin
        w_diff = r_s2E - r_accE;
        w_alA  = shr(r_accM, w_diff);
        w_newE = r_s2E;
      end else begin
        w_diff = r_accE - r_s2E;
        w_alB  = shr(r_s2Sum, w_diff);
        w_newE = r_accE;
      end
      w_wide = {w_alA[ACCW-1], w_alA} + {w_alB[ACCW-1], w_alB};
      if (w_wide[ACCW] != w_wide[ACCW-1]) begin
        w_sat  = 1'b1;
        w_newM = w_wide[ACCW] ? MINV : MAXV;
      end else begin
        w_newM = w_wide[ACCW-1:0];
      end
    end
  end

  // A last beat hands its total to the final stage and empties the accumulator in the same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_accFull  <= 1'b0;
      r_accOvf   <= 1'b0;
      r_accE     <= '0;
      r_accM     <= '0;
      r_cnt      <= '0;
      r_finValid <= 1'b0;
      r_finOvf   <= 1'b0;
      r_finE     <= '0;
      r_finM     <= '0;
      r_finBeats <= '0;
    end else if (w_en) begin
      r_finValid <= r_s2Valid && r_s2Last;
      if (r_s2Valid) begin
        if (r_s2Last) begin
          r_finE     <= w_newE;
          r_finM     <= w_newM;
          r_finOvf   <= r_accOvf | w_sat;
          r_finBeats <= w_cntNext;
          r_accFull  <= 1'b0;
          r_accOvf   <= 1'b0;
          r_accE     <= '0;
          r_accM     <= '0;
          r_cnt      <= '0;
        end else begin
          r_accFull <= 1'b1;
          r_accOvf  <= r_accOvf | w_sat;
          r_accE    <= w_newE;
          r_accM    <= w_newM;
          r_cnt     <= w_cntNext;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_oValid <= 1'b0;
      r_oOvf   <= 1'b0;
      r_oE     <= '0;
      r_oM     <= '0;
      r_oBeats <= '0;
    end else if (w_en) begin
      r_oValid <= r_finValid;
      if (r_finValid) begin
        r_oOvf   <= r_finOvf;
        r_oE     <= r_finE;
        r_oM     <= r_finM;
        r_oBeats <= r_finBeats;
      end
    end
  end

  assign o_valid    = r_oValid;
  assign o_ovf      = r_oOvf;
  assign o_result_E = r_oE;
  assign o_result_M = r_oM;
  assign o_beats    = r_oBeats;

endmodule
